ebpf_unary_alu_pipe: RTL and testbench

- Pipelined, handshaked unary ALU unit for the eBPF core.
- Generalises 64-bit negation to the full eBPF unary class:
  - NEG in ALU64 and ALU32 forms.
  - Endianness conversion (BE/LE, 16/32/64), as used by the BPF_END opcode.
- Parametrised pipeline depth, with a destination-register tag carried alongside each result.
- Sits between decode/register-read and writeback.

---
 rtl/ebpf_unary_alu_pipe.sv | 117 +++++++++++
 tb/tb_ebpf_unary_alu_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ebpf_unary_alu_pipe.sv
// Pipelined eBPF unary ALU: NEG (64/32) and BPF_END byte swaps/truncations.
// The result is formed combinationally and carried with its tag through an elastic stage chain.
module ebpf_unary_alu_pipe #(
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [2:0] {
        OP_NEG64 = 3'b000,
        OP_NEG32 = 3'b001,
        OP_BE16  = 3'b010,
        OP_BE32  = 3'b011,
        OP_BE64  = 3'b100,
        OP_LE16  = 3'b101,
        OP_LE32  = 3'b110,
        OP_LE64  = 3'b111
    } op_t;

    function automatic logic [63:0] bswap64(input logic [63:0] a);
        return {a[7:0], a[15:8], a[23:16], a[31:24],
                a[39:32], a[47:40], a[55:48], a[63:56]};
    endfunction

    function automatic logic [63:0] unary_result(input logic [2:0] op, input logic [63:0] a);
        logic [63:0] r;
        logic [31:0] lo_neg;
        lo_neg = 32'd0 - a[31:0];
        case (op_t'(op))
            OP_NEG64: r = 64'd0 - a;
            OP_NEG32: r = {32'h0, lo_neg};
            OP_BE16:  r = {48'h0, a[7:0], a[15:8]};
            OP_BE32:  r = {32'h0, a[7:0], a[15:8], a[23:16], a[31:24]};
            OP_BE64:  r = bswap64(a);
            OP_LE16:  r = {48'h0, a[15:0]};
            OP_LE32:  r = {32'h0, a[31:0]};
            default:  r = a;
        endcase
        return r;
    endfunction

    logic [STAGES-1:0] vld_p;
    logic [63:0]       data_p [STAGES];
    logic [TAG_W-1:0]  tag_p  [STAGES];

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] mv;
    logic              down_ok;
    logic              in_fire;
    logic [63:0]       result;

    assign result = unary_result(in_op, in_data);

    // Ready ripples back from out_ready: a stage can load if empty or if it drains this cycle.
    always_comb begin
        ld      = '0;
        mv      = '0;
        down_ok = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            mv[k]   = vld_p[k] && down_ok;
            ld[k]   = !vld_p[k] || down_ok;
            down_ok = ld[k];
        end
    end

    assign in_ready  = ld[0] && !flush && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = vld_p[STAGES-1];
    assign out_data  = data_p[STAGES-1];
    assign out_tag   = tag_p[STAGES-1];
    assign busy      = |vld_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_p[k] <= '0;
                tag_p[k]  <= '0;
            end
        end else begin
            if (flush) begin
                vld_p <= '0;
            end else begin
                if (ld[0]) vld_p[0] <= in_fire;
                for (int k = 1; k < STAGES; k++) begin
                    if (ld[k]) vld_p[k] <= mv[k-1];
                end
            end
            // stage 1 captures the computed result
            if (in_fire) begin
                data_p[0] <= result;
                tag_p[0]  <= in_tag;
            end
            // stages 2..STAGES are plain transport registers
            for (int k = 1; k < STAGES; k++) begin
                if (mv[k-1]) begin
                    data_p[k] <= data_p[k-1];
                    tag_p[k]  <= tag_p[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_ebpf_unary_alu_pipe.sv
// Bench for ebpf_unary_alu_pipe: directed vectors, backpressure, random traffic, flush and reset.
module tb_ebpf_unary_alu_pipe;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [63:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    ebpf_unary_alu_pipe #(.STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Reference: BE_n is the low n bytes read in reverse order; LE_n is truncation.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a);
        logic [63:0] rev;
        for (int i = 0; i < 8; i++) rev[8*i +: 8] = a[8*(7-i) +: 8];
        case (op)
            3'd0: return 64'd0 - a;
            3'd1: return (64'h1_0000_0000 - {32'h0, a[31:0]}) & 64'hFFFF_FFFF;
            3'd2: return rev >> 48;
            3'd3: return rev >> 32;
            3'd4: return rev;
            3'd5: return a & 64'hFFFF;
            3'd6: return a & 64'hFFFF_FFFF;
            default: return a;
        endcase
    endfunction

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             q[$];
    logic             hold_prev = 1'b0;
    logic [63:0]      prev_data;
    logic [TAG_W-1:0] prev_tag;

    // Compare process: outputs against the model queue, and stall stability.
    always @(negedge clk) begin
        if (hold_prev && out_valid) begin
            check("stall_data_stable", out_data, prev_data);
            check("stall_tag_stable", 64'(out_tag), 64'(prev_tag));
        end
        if (out_valid && !rst) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got tag %h data %h, expected no output", out_tag, out_data);
            end else begin
                check("sb_data", out_data, q[0].data);
                check("sb_tag", 64'(out_tag), 64'(q[0].tag));
                if (out_ready) void'(q.pop_front());
            end
        end
        hold_prev = out_valid && !out_ready && !rst && !flush;
        prev_data = out_data;
        prev_tag  = out_tag;
        if (rst || flush) q.delete();
        else if (in_valid && in_ready) q.push_back('{ref_result(in_op, in_data), in_tag});
    end

    task automatic single(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] exp, input logic [TAG_W-1:0] tag);
        int cnt;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_data = a; in_tag = tag; out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 64'h0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 20);
        check({name, "_latency"}, 64'(cnt), 64'(STAGES));
        check(name, out_data, exp);
        check({name, "_tag"}, 64'(out_tag), 64'(tag));
    endtask

    task automatic fill_pipe(input logic [63:0] a, input logic [TAG_W-1:0] tag);
        int acc;
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_op = 3'b111; in_data = a; in_tag = tag;
            @(negedge clk);
            if (in_ready) acc++;
            else break;
        end
        check("fill_count", 64'(acc), 64'(STAGES));
        check("fill_busy", 64'(busy), 64'd1);
    endtask

    initial begin
        int next_tag, exp_tag, issued, cyc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'b000; in_data = 64'h0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_tag", 64'(out_tag), 64'h0);

        single("neg64_one", 3'b000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1);
        single("neg64_min", 3'b000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h2);
        single("neg64_zero", 3'b000, 64'h0, 64'h0, 4'h3);
        single("neg32_a", 3'b001, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 4'h4);
        single("neg32_b", 3'b001, 64'h1234_5678_0000_0000, 64'h0, 4'h5);
        single("be16", 3'b010, 64'h1122_3344_5566_7788, 64'h8877, 4'h6);
        single("be32", 3'b011, 64'h1122_3344_5566_7788, 64'h8877_6655, 4'h7);
        single("be64", 3'b100, 64'h1122_3344_5566_7788, 64'h8877_6655_4433_2211, 4'h8);
        single("le16", 3'b101, 64'h1122_3344_5566_7788, 64'h7788, 4'h9);
        single("le32", 3'b110, 64'h1122_3344_5566_7788, 64'h5566_7788, 4'hA);
        single("le64", 3'b111, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 4'hB);

        // Backpressure: tags 0..5 offered while out_ready is held low, then released.
        next_tag = 0; exp_tag = 0;
        for (cyc = 0; cyc < 40 && exp_tag < 6; cyc++) begin
            @(posedge clk); #1;
            out_ready = (cyc >= 8);
            in_valid  = (next_tag < 6);
            in_op     = 3'b000;
            in_data   = 64'(next_tag + 1);
            in_tag    = TAG_W'(next_tag);
            @(negedge clk);
            if (cyc == 7) begin
                check("bp_accepted", 64'(next_tag), 64'(STAGES));
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
            end
            if (cyc >= 8) check("bp_no_bubble", 64'(out_valid), 64'd1);
            if (in_valid && in_ready) next_tag++;
            if (out_valid && out_ready) begin
                check("bp_order", 64'(out_tag), 64'(exp_tag));
                exp_tag++;
            end
        end
        check("bp_all_out", 64'(exp_tag), 64'd6);

        // Random traffic with random backpressure.
        issued = 0;
        for (int i = 0; i < 4000 && issued < 1000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       in_data = 64'h0;
                1:       in_data = 64'h8000_0000_0000_0000;
                default: in_data = {$urandom, $urandom};
            endcase
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            if (in_valid && in_ready) issued++;
        end
        check("rand_issued", 64'(issued), 64'd1000);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        @(negedge clk);
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_queue_empty", 64'(q.size()), 64'd0);

        // Flush with a full pipe; an op offered during flush must not be taken.
        fill_pipe(64'hCAFE_F00D_1234_5678, 4'hC);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready_after", 64'(in_ready), 64'd1);

        // Reset mid-stream: as flush, and data/tag registers cleared.
        fill_pipe(64'hFFFF_FFFF_FFFF_FFFF, 4'hA);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_in_ready_after", 64'(in_ready), 64'd1);
        check("rst_mid_out_data", out_data, 64'h0);
        check("rst_mid_out_tag", 64'(out_tag), 64'h0);

        // Unit still works after reset.
        single("post_rst_be64", 3'b100, 64'h0102_0304_0506_0708, 64'h0807_0605_0403_0201, 4'hD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end
endmodule
